// File: rtl/mouse_cursor_tracker.sv
// Converts per-report direction flags and magnitudes into a saturating absolute
// cursor position, with stretched direction LEDs, a debounced click and an edge flag.
module mouse_cursor_tracker #(
  parameter int POS_W       = 10,
  parameter int MAG_W       = 8,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int HOLD_CYCLES = 4,
  parameter int DEBOUNCE    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample,
  input  logic             Izquierda,
  input  logic             Derecha,
  input  logic             Arriba,
  input  logic             Abajo,
  input  logic [MAG_W-1:0] MagX,
  input  logic [MAG_W-1:0] MagY,
  input  logic             Click,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             led0,
  output logic             led1,
  output logic             led2,
  output logic             led3,
  output logic             led4,
  output logic             led5,
  output logic             click_pulse
);

  // One bit beyond sign+magnitude so a sum of two full-scale operands cannot wrap.
  localparam int W  = ((POS_W > MAG_W) ? POS_W : MAG_W) + 2;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);

  localparam logic signed [W-1:0] XMAX_S = W'(X_MAX);
  localparam logic signed [W-1:0] YMAX_S = W'(Y_MAX);

  // Returns {clipped, new position}.
  function automatic logic [POS_W:0] step(
    input logic [POS_W-1:0]    pos,
    input logic [MAG_W-1:0]    mag,
    input logic                dec,
    input logic                inc,
    input logic signed [W-1:0] maxv
  );
    logic signed [W-1:0] p;
    logic signed [W-1:0] m;
    logic signed [W-1:0] r;
    p = W'(pos);
    m = W'(mag);
    if (dec && !inc)      r = p - m;
    else if (inc && !dec) r = p + m;
    else                  r = p;
    if (r < 0)         step = {1'b1, {POS_W{1'b0}}};
    else if (r > maxv) step = {1'b1, maxv[POS_W-1:0]};
    else               step = {1'b0, r[POS_W-1:0]};
  endfunction

  logic [POS_W:0]  nx;
  logic [POS_W:0]  ny;
  logic [3:0]      eff;
  logic [HW-1:0]   hold [4];
  logic            sync1;
  logic            sync2;
  logic [DW-1:0]   dcnt;

  always_comb begin
    nx     = step(pos_x, MagX, Izquierda, Derecha, XMAX_S);
    ny     = step(pos_y, MagY, Arriba, Abajo, YMAX_S);
    eff    = '0;
    eff[0] = sample && Izquierda && !Derecha && (MagX != '0);
    eff[1] = sample && Derecha && !Izquierda && (MagX != '0);
    eff[2] = sample && Arriba && !Abajo && (MagY != '0);
    eff[3] = sample && Abajo && !Arriba && (MagY != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x <= POS_W'(X_MAX / 2);
      pos_y <= POS_W'(Y_MAX / 2);
      led5  <= 1'b0;
    end else if (sample) begin
      pos_x <= nx[POS_W-1:0];
      pos_y <= ny[POS_W-1:0];
      led5  <= nx[POS_W] | ny[POS_W];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (reset)                hold[i] <= '0;
      else if (eff[i])          hold[i] <= HW'(HOLD_CYCLES);
      else if (hold[i] != '0)   hold[i] <= hold[i] - HW'(1);
    end
  end

  assign led0 = (hold[0] != '0);
  assign led1 = (hold[1] != '0);
  assign led2 = (hold[2] != '0);
  assign led3 = (hold[3] != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      dcnt        <= '0;
      led4        <= 1'b0;
      click_pulse <= 1'b0;
    end else begin
      sync1       <= Click;
      sync2       <= sync1;
      click_pulse <= 1'b0;
      if (sync2 != led4) begin
        if (dcnt == DW'(DEBOUNCE - 1)) begin
          led4        <= ~led4;
          click_pulse <= ~led4;
          dcnt        <= '0;
        end else begin
          dcnt <= dcnt + DW'(1);
        end
      end else begin
        dcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Directed bench for mouse_cursor_tracker: vector table for position/clip/LED
// behaviour plus hand sequences for LED stretch, debounce and mid-run reset.
module tb_mouse_cursor_tracker;

  logic       clk = 1'b0;
  logic       reset, sample, Izquierda, Derecha, Arriba, Abajo, Click;
  logic [7:0] MagX, MagY;
  logic [9:0] pos_x, pos_y;
  logic       led0, led1, led2, led3, led4, led5, click_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mouse_cursor_tracker #(
    .POS_W(10), .MAG_W(8), .X_MAX(639), .Y_MAX(479), .HOLD_CYCLES(4), .DEBOUNCE(3)
  ) dut (
    .clk(clk), .reset(reset), .sample(sample),
    .Izquierda(Izquierda), .Derecha(Derecha), .Arriba(Arriba), .Abajo(Abajo),
    .MagX(MagX), .MagY(MagY), .Click(Click),
    .pos_x(pos_x), .pos_y(pos_y),
    .led0(led0), .led1(led1), .led2(led2), .led3(led3), .led4(led4), .led5(led5),
    .click_pulse(click_pulse)
  );

  typedef struct {
    bit       rst;
    bit       l, r, u, d;
    int       mx, my;
    int       ex, ey;
    bit       e5;
    bit [3:0] eleds;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_sample(input bit l, r, u, d, input int mx, my);
    Izquierda = l; Derecha = r; Arriba = u; Abajo = d;
    MagX = 8'(mx); MagY = 8'(my);
    sample = 1'b1;
    tick();
    sample = 1'b0;
    Izquierda = 1'b0; Derecha = 1'b0; Arriba = 1'b0; Abajo = 1'b0;
    MagX = '0; MagY = '0;
  endtask

  function automatic int leds();
    return int'({led3, led2, led1, led0});
  endfunction

  initial begin
    reset = 1'b1; sample = 1'b0; Click = 1'b0;
    Izquierda = 1'b0; Derecha = 1'b0; Arriba = 1'b0; Abajo = 1'b0;
    MagX = '0; MagY = '0;

    //          rst l r u d  mx   my   ex   ey  e5 {d,u,r,l}
    tbl[0]  = '{1, 0,1,0,1,  15,  15, 334, 254, 0, 4'b1010};
    tbl[1]  = '{1, 1,0,0,0, 255,   0,  64, 239, 0, 4'b0001};
    tbl[2]  = '{0, 1,0,0,0, 255,   0,   0, 239, 1, 4'b0001};
    tbl[3]  = '{0, 0,1,0,0,   1,   0,   1, 239, 0, 4'b0010};
    tbl[4]  = '{0, 1,1,1,0,  15,   0,   1, 239, 0, 4'b0000};
    tbl[5]  = '{1, 0,1,0,0, 255,   0, 574, 239, 0, 4'b0010};
    tbl[6]  = '{0, 0,1,0,0, 255,   0, 639, 239, 1, 4'b0010};
    tbl[7]  = '{0, 0,1,0,0,   0,   0, 639, 239, 0, 4'b0000};
    tbl[8]  = '{0, 0,0,0,1,   0, 240, 639, 479, 0, 4'b1000};
    tbl[9]  = '{0, 0,0,1,0,   0, 255, 639, 224, 0, 4'b0100};
    tbl[10] = '{0, 0,0,1,0,   0, 255, 639,   0, 1, 4'b0100};
    tbl[11] = '{0, 1,0,0,1, 100, 200, 539, 200, 0, 4'b1001};
    tbl[12] = '{0, 0,1,0,1, 200, 255, 639, 455, 1, 4'b1010};
    tbl[13] = '{0, 1,0,0,1, 200, 100, 439, 479, 1, 4'b1001};

    tick(); tick();
    reset = 1'b0;
    check("reset_pos_x", int'(pos_x), 319);
    check("reset_pos_y", int'(pos_y), 239);
    check("reset_leds", int'({click_pulse, led5, led4, led3, led2, led1, led0}), 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      do_sample(tbl[i].l, tbl[i].r, tbl[i].u, tbl[i].d, tbl[i].mx, tbl[i].my);
      check($sformatf("vec%0d_pos_x", i), int'(pos_x), tbl[i].ex);
      check($sformatf("vec%0d_pos_y", i), int'(pos_y), tbl[i].ey);
      check($sformatf("vec%0d_led5", i), int'(led5), int'(tbl[i].e5));
      check($sformatf("vec%0d_leds", i), leds(), int'(tbl[i].eleds));
      repeat (5) tick();
      check($sformatf("vec%0d_leds_decayed", i), leds(), 0);
    end

    // sample low: flags ignored, position and led5 hold
    Izquierda = 1'b1; MagX = 8'd50;
    tick();
    check("idle_pos_x", int'(pos_x), 439);
    check("idle_led5", int'(led5), 1);
    check("idle_led0", int'(led0), 0);
    Izquierda = 1'b0; MagX = '0;

    // back-to-back samples
    do_reset();
    Izquierda = 1'b1; MagX = 8'd255; sample = 1'b1;
    tick();
    check("b2b_first_x", int'(pos_x), 64);
    check("b2b_first_led5", int'(led5), 0);
    tick();
    check("b2b_second_x", int'(pos_x), 0);
    check("b2b_second_led5", int'(led5), 1);
    sample = 1'b0; Izquierda = 1'b0; MagX = '0;

    // stretch and retrigger: sample at step 0 and step 3, lit through step 6
    do_reset();
    for (int k = 0; k < 9; k++) begin
      if (k == 0 || k == 3) do_sample(1, 0, 0, 0, 5, 0);
      else tick();
      check($sformatf("stretch_led0_step%0d", k), int'(led0), (k <= 6) ? 1 : 0);
    end

    // glitch of 2 cycles never changes led4
    do_reset();
    Click = 1'b1;
    tick(); tick();
    Click = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < 8; k++) begin
        tick();
        seen |= int'(led4) | int'(click_pulse);
      end
      check("glitch_no_change", seen, 0);
    end

    // held press: led4 rises on 5th edge with single pulse
    Click = 1'b1;
    begin
      int pulses = 0;
      for (int k = 1; k <= 8; k++) begin
        tick();
        pulses += int'(click_pulse);
        if (k == 4) check("press_led4_edge4", int'(led4), 0);
        if (k == 5) begin
          check("press_led4_edge5", int'(led4), 1);
          check("press_pulse_edge5", int'(click_pulse), 1);
        end
        if (k == 6) check("press_pulse_edge6", int'(click_pulse), 0);
      end
      check("press_pulse_count", pulses, 1);
    end

    // release: led4 falls 5 edges later, no pulse
    Click = 1'b0;
    begin
      int pulses = 0;
      for (int k = 1; k <= 7; k++) begin
        tick();
        pulses += int'(click_pulse);
        if (k == 4) check("release_led4_edge4", int'(led4), 1);
        if (k == 5) check("release_led4_edge5", int'(led4), 0);
      end
      check("release_pulse_count", pulses, 0);
    end

    // reset with led0 lit and debounce count at 2
    do_reset();
    Click = 1'b1;
    tick(); tick();
    do_sample(1, 0, 0, 0, 10, 0);
    tick();
    check("pre_reset_pos_x", int'(pos_x), 309);
    check("pre_reset_led0", int'(led0), 1);
    reset = 1'b1; Click = 1'b0;
    tick();
    reset = 1'b0;
    check("midreset_pos_x", int'(pos_x), 319);
    check("midreset_pos_y", int'(pos_y), 239);
    check("midreset_leds", int'({click_pulse, led5, led4, led3, led2, led1, led0}), 0);
    Click = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 4) check("post_reset_led4_edge4", int'(led4), 0);
      if (k == 5) check("post_reset_led4_edge5", int'(led4), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
